// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: mode encodings and a width helper.
package stream_demux_pkg;

  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Count-based synchronous FIFO for one output channel; read data reads as zero while empty.
module demux_fifo
  import stream_demux_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = clog2w(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [PTR_W:0]    count;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rptr];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/stream_demux_buf.sv
// Routes one valid/ready stream to NUM_CH FIFO-buffered channels, by explicit select or round-robin.
module stream_demux_buf
  import stream_demux_pkg::*;
#(
  parameter int  DATA_W     = 8,
  parameter int  NUM_CH     = 4,
  parameter int  FIFO_DEPTH = 4,
  localparam int SEL_W      = clog2w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        ch_full,
  output logic                     err_sel
);

  localparam logic [SEL_W:0]   NUM_CH_C = (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  logic [SEL_W-1:0]  rr_ptr, tgt;
  logic              sel_ok, tgt_full, accept;
  logic [NUM_CH-1:0] full, empty, push, pop;

  // Readiness looks only at registered counts: a full FIFO popping this cycle still stalls.
  always_comb begin
    tgt      = (mode == MODE_RR) ? rr_ptr : in_sel;
    sel_ok   = ({1'b0, tgt} < NUM_CH_C);
    tgt_full = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (tgt == SEL_W'(c)) tgt_full = full[c];
    in_ready = sel_ok ? !tgt_full : 1'b1;
    accept   = in_valid && in_ready;
  end

  assign out_valid = ~empty;
  assign ch_full   = full;
  assign pop       = out_valid & out_ready;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign push[c] = accept && sel_ok && (tgt == SEL_W'(c));

    demux_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[c]),
      .pop   (pop[c]),
      .wdata (in_data),
      .rdata (out_data[c*DATA_W +: DATA_W]),
      .empty (empty[c]),
      .full  (full[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      err_sel <= 1'b0;
    end else begin
      if (accept && mode == MODE_RR)
        rr_ptr <= (rr_ptr == LAST_CH) ? '0 : rr_ptr + 1'b1;
      // Out-of-range beats are swallowed; remember that it happened.
      if (in_valid && mode == MODE_DIRECTED && !sel_ok)
        err_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_demux_buf.sv
// Self-checking bench: vector table, queue-based reference model with random traffic, invalid-select and reset sequences.
module tb_stream_demux_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode, in_valid, in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready, ch_full;
  logic [31:0] out_data;
  logic        err_sel;

  logic        b_mode, b_valid, b_ready, b_err;
  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic [2:0]  b_ovalid, b_oready, b_full;
  logic [23:0] b_odata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_demux_buf #(.DATA_W(8), .NUM_CH(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .ch_full(ch_full), .err_sel(err_sel)
  );

  stream_demux_buf #(.DATA_W(8), .NUM_CH(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_data), .in_sel(b_sel), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_data(b_odata), .ch_full(b_full), .err_sel(b_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: one queue per channel plus round-robin index.
  logic [7:0] mq [4][$];
  int         rr_m = 0;

  task automatic step();
    logic [3:0]  eov, efull;
    logic [31:0] ed;
    logic        erdy;
    int          tgt;
    @(negedge clk);
    eov = '0; efull = '0; ed = '0;
    for (int c = 0; c < 4; c++) begin
      if (mq[c].size() > 0) begin
        eov[c] = 1'b1;
        ed[c*8 +: 8] = mq[c][0];
      end
      efull[c] = (mq[c].size() == 4);
    end
    chk("m_out_valid", {28'd0, out_valid}, {28'd0, eov});
    chk("m_out_data", out_data, ed);
    chk("m_ch_full", {28'd0, ch_full}, {28'd0, efull});
    chk("m_err_sel", {31'd0, err_sel}, 32'd0);
    tgt  = mode ? rr_m : int'(in_sel);
    erdy = (mq[tgt].size() < 4);
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, erdy});
    if (rst) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
      rr_m = 0;
    end else begin
      for (int c = 0; c < 4; c++)
        if (mq[c].size() > 0 && out_ready[c]) void'(mq[c].pop_front());
      if (in_valid && erdy) begin
        mq[tgt].push_back(in_data);
        if (mode) rr_m = (rr_m + 1) % 4;
      end
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       md, vld;
    logic [1:0] sel;
    logic [7:0] d;
    logic [3:0] ordy;
    logic       rdy;
    logic [3:0] ov, full;
    int         ch;
    logic [7:0] hd;
  } vec_t;
  vec_t tv[$];

  task automatic tv_add(input logic md, input logic vld, input logic [1:0] sel, input logic [7:0] d,
                        input logic [3:0] ordy, input logic rdy, input logic [3:0] ov,
                        input logic [3:0] full, input int ch, input logic [7:0] hd);
    vec_t v;
    v.md = md; v.vld = vld; v.sel = sel; v.d = d; v.ordy = ordy;
    v.rdy = rdy; v.ov = ov; v.full = full; v.ch = ch; v.hd = hd;
    tv.push_back(v);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    b_mode = 1'b0; b_valid = 1'b0; b_data = '0; b_sel = '0; b_oready = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_ch_full", {28'd0, ch_full}, 32'd0);
    chk("rst_err_sel", {31'd0, err_sel}, 32'd0);
    rst = 1'b0;

    //      md   vld  sel    d      ordy     rdy  ov       full    ch hd
    tv_add(1'b0,1'b1,2'd2,8'h11,4'b1111,1'b1,4'b0100,4'b0000,2,8'h11);
    tv_add(1'b0,1'b0,2'd2,8'h00,4'b1111,1'b1,4'b0000,4'b0000,2,8'h00);
    tv_add(1'b0,1'b1,2'd1,8'hA0,4'b1101,1'b1,4'b0010,4'b0000,1,8'hA0);
    tv_add(1'b0,1'b1,2'd1,8'hA1,4'b1101,1'b1,4'b0010,4'b0000,1,8'hA0);
    tv_add(1'b0,1'b1,2'd1,8'hA2,4'b1101,1'b1,4'b0010,4'b0000,1,8'hA0);
    tv_add(1'b0,1'b1,2'd1,8'hA3,4'b1101,1'b1,4'b0010,4'b0010,1,8'hA0);
    tv_add(1'b0,1'b1,2'd1,8'hA4,4'b1101,1'b0,4'b0010,4'b0010,1,8'hA0);
    tv_add(1'b0,1'b1,2'd1,8'hA4,4'b1111,1'b0,4'b0010,4'b0000,1,8'hA1);
    tv_add(1'b0,1'b1,2'd1,8'hA4,4'b1111,1'b1,4'b0010,4'b0000,1,8'hA2);
    tv_add(1'b0,1'b0,2'd1,8'h00,4'b1111,1'b1,4'b0010,4'b0000,1,8'hA3);
    tv_add(1'b0,1'b0,2'd1,8'h00,4'b1111,1'b1,4'b0010,4'b0000,1,8'hA4);
    tv_add(1'b0,1'b0,2'd1,8'h00,4'b1111,1'b1,4'b0000,4'b0000,1,8'h00);
    tv_add(1'b1,1'b1,2'd3,8'h01,4'b0000,1'b1,4'b0001,4'b0000,0,8'h01);
    tv_add(1'b1,1'b1,2'd3,8'h02,4'b0000,1'b1,4'b0011,4'b0000,1,8'h02);
    tv_add(1'b1,1'b1,2'd3,8'h03,4'b0000,1'b1,4'b0111,4'b0000,2,8'h03);
    tv_add(1'b1,1'b1,2'd3,8'h04,4'b0000,1'b1,4'b1111,4'b0000,3,8'h04);
    tv_add(1'b1,1'b1,2'd3,8'h05,4'b0000,1'b1,4'b1111,4'b0000,0,8'h01);
    tv_add(1'b1,1'b1,2'd3,8'h06,4'b0000,1'b1,4'b1111,4'b0000,1,8'h02);
    tv_add(1'b0,1'b1,2'd0,8'h07,4'b0000,1'b1,4'b1111,4'b0000,0,8'h01);
    tv_add(1'b0,1'b1,2'd0,8'h08,4'b0000,1'b1,4'b1111,4'b0001,0,8'h01);
    tv_add(1'b1,1'b1,2'd0,8'h09,4'b0000,1'b1,4'b1111,4'b0001,2,8'h03);
    tv_add(1'b1,1'b0,2'd0,8'h00,4'b1111,1'b1,4'b0111,4'b0000,2,8'h09);
    tv_add(1'b1,1'b0,2'd0,8'h00,4'b1111,1'b1,4'b0001,4'b0000,0,8'h07);
    tv_add(1'b1,1'b0,2'd0,8'h00,4'b1111,1'b1,4'b0001,4'b0000,0,8'h08);
    tv_add(1'b1,1'b0,2'd0,8'h00,4'b1111,1'b1,4'b0000,4'b0000,0,8'h00);

    foreach (tv[i]) begin
      mode = tv[i].md; in_valid = tv[i].vld; in_sel = tv[i].sel;
      in_data = tv[i].d; out_ready = tv[i].ordy;
      #1;
      chk($sformatf("tv%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].rdy});
      step();
      chk($sformatf("tv%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tv[i].ov});
      chk($sformatf("tv%0d_ch_full", i), {28'd0, ch_full}, {28'd0, tv[i].full});
      chk($sformatf("tv%0d_head", i), {24'd0, out_data[tv[i].ch*8 +: 8]}, {24'd0, tv[i].hd});
    end
    in_valid = 1'b0;

    // Three-channel instance: select 3 is out of range.
    b_valid = 1'b1; b_sel = 2'd3; b_data = 8'h55;
    #1;
    chk("b_badsel_in_ready", {31'd0, b_ready}, 32'd1);
    step();
    chk("b_badsel_out_valid", {29'd0, b_ovalid}, 32'd0);
    chk("b_badsel_err", {31'd0, b_err}, 32'd1);
    b_sel = 2'd0; b_data = 8'h66;
    step();
    chk("b_good_out_valid", {29'd0, b_ovalid}, 32'd1);
    chk("b_good_data", {24'd0, b_odata[7:0]}, 32'h66);
    chk("b_err_sticky", {31'd0, b_err}, 32'd1);
    b_valid = 1'b0;
    repeat (3) step();
    chk("b_err_hold", {31'd0, b_err}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      step();
    end

    // Fill partly, then reset mid-stream.
    mode = 1'b1; out_ready = '0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      step();
    end
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("mid_rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_ch_full", {28'd0, ch_full}, 32'd0);
    chk("mid_rst_err_sel", {31'd0, err_sel}, 32'd0);
    chk("mid_rst_b_err", {31'd0, b_err}, 32'd0);
    rst = 1'b0; mode = 1'b1; in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd3;
    step();
    chk("post_rst_rr_valid", {28'd0, out_valid}, 32'd1);
    chk("post_rst_rr_data", {24'd0, out_data[7:0]}, 32'h77);
    in_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
